// File: rtl/encoder_pkg.sv
// Shared widths and types for the 16-to-4 priority encoder.
package encoder_pkg;
    localparam int ENC_IN_W  = 16;
    localparam int ENC_OUT_W = 4;

    typedef logic [ENC_OUT_W-1:0] enc_code_t;
endpackage

// File: rtl/encoder_prio_comb.sv
// Combinational priority scan: the highest-numbered set bit of req sets code.
module encoder_prio_comb
    import encoder_pkg::*;
#(
    parameter int IN_W  = ENC_IN_W,
    parameter int OUT_W = $clog2(IN_W)
) (
    input  logic [IN_W-1:0]  req,
    output logic [OUT_W-1:0] code,
    output logic             valid
);

    // Scan upward so a later (higher) hit overwrites any earlier one.
    always_comb begin
        code  = '0;
        valid = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (req[i]) begin
                code  = OUT_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_16to4.sv
// Registered priority encoder: combinational decode followed by one flop stage.
module encoder_16to4
    import encoder_pkg::*;
#(
    parameter int IN_W  = ENC_IN_W,
    parameter int OUT_W = $clog2(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  Encoder_In,
    output logic [OUT_W-1:0] Binary_Out,
    output logic             Valid_Out
);

    logic [OUT_W-1:0] code_p0;
    logic             vld_p0;
    logic [OUT_W-1:0] code_p1;
    logic             vld_p1;

    encoder_prio_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_prio (
        .req   (Encoder_In),
        .code  (code_p0),
        .valid (vld_p0)
    );

    // Stage p0 -> p1: code is cleared with valid so reset presents a clean zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            code_p1 <= code_p0;
            vld_p1  <= vld_p0;
        end
    end

    assign Binary_Out = code_p1;
    assign Valid_Out  = vld_p1;

endmodule

// File: tb/tb_encoder_16to4.sv
// Directed bench for encoder_16to4 with hand-computed expected codes.
module tb_encoder_16to4;

    logic        clk;
    logic        rst_n;
    logic [15:0] Encoder_In;
    logic [3:0]  Binary_Out;
    logic        Valid_Out;

    int n_cmp;
    int n_bad;

    encoder_16to4 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Encoder_In (Encoder_In),
        .Binary_Out (Binary_Out),
        .Valid_Out  (Valid_Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present vec, clock once, sample 1ns after the edge and check both outputs.
    task automatic apply(input logic [15:0] vec, input string tag,
                         input int exp_code, input int exp_vld);
        Encoder_In = vec;
        @(posedge clk);
        #1;
        check({tag, " code"}, int'(Binary_Out), exp_code);
        check({tag, " valid"}, int'(Valid_Out), exp_vld);
    endtask

    int sweep_code [11] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3};

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        Encoder_In = 16'hFFFF;
        #2;

        for (int c = 0; c < 2; c++)
            apply(16'hFFFF, $sformatf("reset cyc%0d", c), 0, 0);

        rst_n = 1'b1;
        apply(16'h0000, "zero", 0, 0);
        apply(16'h0001, "bit0", 0, 1);
        apply(16'h0002, "bit1", 1, 1);

        for (int v = 0; v <= 10; v++)
            apply(16'(v), $sformatf("sweep %0h", v), sweep_code[v], (v != 0) ? 1 : 0);

        for (int k = 0; k < 16; k++)
            apply(16'(1) << k, $sformatf("walk %0d", k), k, 1);

        apply(16'h8000, "msb 8000", 15, 1);
        apply(16'hFFFF, "msb FFFF", 15, 1);
        apply(16'h8001, "msb 8001", 15, 1);

        apply(16'h0100, "mid pre", 8, 1);
        rst_n = 1'b0;
        apply(16'h0100, "mid rst", 0, 0);
        rst_n = 1'b1;
        apply(16'h0100, "mid post", 8, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
